// File: rtl/ysyx_24080014_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_pkg                                               |
// | Purpose  : Shared constants for write-back arbitration and CSR control.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ysyx_24080014_pkg;

    localparam int         WB_N   = 3;
    localparam logic [1:0] WB_EXU = 2'd0;
    localparam logic [1:0] WB_LSU = 2'd1;
    localparam logic [1:0] WB_CSR = 2'd2;

    localparam logic [11:0] CSR_NONE    = 12'h000;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        CTL_NONE  = 2'd0,
        CTL_ECALL = 2'd1,
        CTL_MRET  = 2'd2
    } csr_ctl_e;

    // Requester that follows idx in the exu -> lsu -> csr ring.
    function automatic logic [1:0] wb_next(input logic [1:0] idx);
        return (idx == WB_CSR) ? WB_EXU : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_rr_arb3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_rr_arb3                                           |
// | Purpose  : 3-way one-hot grant. Round-robin when YSYX_24080014_WB_RR_EN is |
// |            defined, otherwise fixed priority csr > lsu > exu.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ysyx_24080014_rr_arb3
    import ysyx_24080014_pkg::*;
(
`ifdef YSYX_24080014_WB_RR_EN
    input  logic            clk,
`endif
    input  logic            rst_n,
    input  logic [WB_N-1:0] i_req,
    output logic [WB_N-1:0] o_grant
);

`ifdef YSYX_24080014_WB_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] w_win;
    logic       w_hit;
    logic [2:0] w_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= WB_EXU;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Scan the ring starting at the pointer; the first requester found wins.
    always_comb begin
        w_hit  = 1'b0;
        w_win  = WB_EXU;
        w_slot = 3'd0;
        for (int k = 0; k < WB_N; k++) begin
            w_slot = {1'b0, r_ptr} + 3'(k);
            if (w_slot >= 3'(WB_N)) begin
                w_slot = w_slot - 3'(WB_N);
            end
            if (!w_hit && i_req[w_slot[1:0]]) begin
                w_hit = 1'b1;
                w_win = w_slot[1:0];
            end
        end
        w_ptr_nxt = w_hit ? wb_next(w_win) : r_ptr;
    end

    always_comb begin
        o_grant = '0;
        if (w_hit && rst_n) begin
            o_grant[w_win] = 1'b1;
        end
    end
`else
    always_comb begin
        o_grant = '0;
        if (rst_n) begin
            if (i_req[WB_CSR]) begin
                o_grant[WB_CSR] = 1'b1;
            end else if (i_req[WB_LSU]) begin
                o_grant[WB_LSU] = 1'b1;
            end else if (i_req[WB_EXU]) begin
                o_grant[WB_EXU] = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_wbu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_wbu_arb                                           |
// | Purpose  : Write-back arbiter, GPR write-port register and busy scoreboard.|
// |            Policy selected by YSYX_24080014_WB_RR_EN (see rr_arb3).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ysyx_24080014_wbu_arb
    import ysyx_24080014_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_GPR = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      exu_valid,
    output logic                      exu_ready,
    input  logic [$clog2(NR_GPR)-1:0] exu_rd,
    input  logic [XLEN-1:0]           exu_data,

    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [$clog2(NR_GPR)-1:0] lsu_rd,
    input  logic [XLEN-1:0]           lsu_data,

    input  logic                      csr_valid,
    output logic                      csr_ready,
    input  logic [$clog2(NR_GPR)-1:0] csr_rd,
    input  logic [XLEN-1:0]           csr_data,
    input  logic [11:0]               csr_waddr,
    input  logic [1:0]                csr_ctl,

    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [$clog2(NR_GPR)-1:0] iss_rs1,
    input  logic [$clog2(NR_GPR)-1:0] iss_rs2,
    input  logic [$clog2(NR_GPR)-1:0] iss_rd,
    input  logic                      iss_rs1_en,
    input  logic                      iss_rs2_en,
    input  logic                      iss_rd_en,

    output logic                      RegWr,
    output logic [$clog2(NR_GPR)-1:0] rd,
    output logic [XLEN-1:0]           rd_data,
    output logic [11:0]               csrs_rs1_write_add,
    output logic [1:0]                csrs_ctl
);

    localparam int IDX_W = $clog2(NR_GPR);

    logic [WB_N-1:0]   w_req;
    logic [WB_N-1:0]   w_grant;
    logic              w_fire;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_rd;
    logic [XLEN-1:0]   w_data;
    logic [11:0]       w_caddr;
    logic [1:0]        w_cctl;

    logic              r_regwr;
    logic [IDX_W-1:0]  r_rd;
    logic [XLEN-1:0]   r_data;
    logic [11:0]       r_caddr;
    logic [1:0]        r_cctl;

    logic [NR_GPR-1:0] r_busy;
    logic [NR_GPR-1:0] w_busy_nxt;
    logic              w_iss_set;

    assign w_req = {csr_valid, lsu_valid, exu_valid};

    ysyx_24080014_rr_arb3 u_arb (
`ifdef YSYX_24080014_WB_RR_EN
        .clk     (clk),
`endif
        .rst_n   (rst_n),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign exu_ready = w_grant[WB_EXU];
    assign lsu_ready = w_grant[WB_LSU];
    assign csr_ready = w_grant[WB_CSR];
    assign w_fire    = |(w_req & w_grant);

    // CSR wins always raise the write enable: the GPR file gates CSR writes with it.
    always_comb begin
        w_rd    = '0;
        w_data  = '0;
        w_caddr = CSR_NONE;
        w_cctl  = CTL_NONE;
        w_wr_en = 1'b0;
        if (w_grant[WB_CSR]) begin
            w_rd    = csr_rd;
            w_data  = csr_data;
            w_caddr = csr_waddr;
            w_cctl  = csr_ctl;
            w_wr_en = 1'b1;
        end else if (w_grant[WB_LSU]) begin
            w_rd    = lsu_rd;
            w_data  = lsu_data;
            w_wr_en = (lsu_rd != '0);
        end else if (w_grant[WB_EXU]) begin
            w_rd    = exu_rd;
            w_data  = exu_data;
            w_wr_en = (exu_rd != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwr <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_caddr <= CSR_NONE;
            r_cctl  <= CTL_NONE;
        end else begin
            r_regwr <= w_fire & w_wr_en;
            if (w_fire) begin
                r_rd    <= w_rd;
                r_data  <= w_data;
                r_caddr <= w_caddr;
                r_cctl  <= w_cctl;
            end
        end
    end

    assign RegWr              = r_regwr;
    assign rd                 = r_rd;
    assign rd_data            = r_data;
    assign csrs_rs1_write_add = r_caddr;
    assign csrs_ctl           = r_cctl;

    assign iss_ready = !(iss_rs1_en && r_busy[iss_rs1])
                     & !(iss_rs2_en && r_busy[iss_rs2])
                     & !(iss_rd_en  && r_busy[iss_rd]);

    assign w_iss_set = iss_valid & iss_ready & iss_rd_en & (iss_rd != '0);

    // Retire clears first so a same-cycle issue to that index keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_regwr) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_wbu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ysyx_24080014_wbu_arb                                        |
// | Purpose  : Directed + random bench against a behavioural arbiter model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ysyx_24080014_wbu_arb;
    import ysyx_24080014_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, lsu_valid, csr_valid;
    logic        exu_ready, lsu_ready, csr_ready;
    logic [4:0]  exu_rd, lsu_rd, csr_rd;
    logic [31:0] exu_data, lsu_data, csr_data;
    logic [11:0] csr_waddr;
    logic [1:0]  csr_ctl;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_rs1_en, iss_rs2_en, iss_rd_en;
    logic        RegWr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [11:0] csrs_rs1_write_add;
    logic [1:0]  csrs_ctl;

    always #5 clk = ~clk;

    ysyx_24080014_wbu_arb #(.XLEN(32), .NR_GPR(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_rd(csr_rd), .csr_data(csr_data),
        .csr_waddr(csr_waddr), .csr_ctl(csr_ctl),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
        .RegWr(RegWr), .rd(rd), .rd_data(rd_data),
        .csrs_rs1_write_add(csrs_rs1_write_add), .csrs_ctl(csrs_ctl)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Requester payloads (index 0 exu, 1 lsu, 2 csr)
    logic        rv  [3];
    logic [4:0]  rrd [3];
    logic [31:0] rdat[3];
    logic [11:0] ccaddr;
    logic [1:0]  ccctl;

    // Reference model state
    int          mptr;
    bit          mbusy[32];
    logic        e_regwr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [11:0] e_caddr;
    logic [1:0]  e_cctl;
    int          last_win;

    logic [11:0] caddr_tab[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        exu_valid = rv[0]; exu_rd = rrd[0]; exu_data = rdat[0];
        lsu_valid = rv[1]; lsu_rd = rrd[1]; lsu_data = rdat[1];
        csr_valid = rv[2]; csr_rd = rrd[2]; csr_data = rdat[2];
        csr_waddr = ccaddr; csr_ctl = ccctl;
    endtask

    task automatic set_req(input int r, input logic v, input logic [4:0] d, input logic [31:0] x);
        rv[r] = v; rrd[r] = d; rdat[r] = x;
    endtask

    task automatic set_iss(input logic v, input logic [4:0] s1, input logic s1e,
                           input logic [4:0] s2, input logic s2e,
                           input logic [4:0] d, input logic de);
        iss_valid = v; iss_rs1 = s1; iss_rs1_en = s1e; iss_rs2 = s2; iss_rs2_en = s2e;
        iss_rd = d; iss_rd_en = de;
    endtask

    task automatic model_reset();
        mptr = 0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        e_regwr = 1'b0; e_rd = '0; e_data = '0; e_caddr = '0; e_cctl = '0;
        last_win = -1;
    endtask

    // One clock: check grant/iss_ready mid-cycle, advance the model, check the write port.
    task automatic step();
        int         win;
        logic [2:0] v;
        logic [2:0] g;
        logic       ir;
        drive();
        @(negedge clk);
        v   = {csr_valid, lsu_valid, exu_valid};
        win = -1;
`ifdef YSYX_24080014_WB_RR_EN
        for (int k = 0; k < 3; k++) begin
            if (win < 0 && v[(mptr + k) % 3]) win = (mptr + k) % 3;
        end
`else
        if (v[2]) win = 2; else if (v[1]) win = 1; else if (v[0]) win = 0;
`endif
        g = 3'b000;
        if (win >= 0) g[win] = 1'b1;
        chk("ready", {61'd0, csr_ready, lsu_ready, exu_ready}, {61'd0, g});
        ir = !((iss_rs1_en && mbusy[iss_rs1]) || (iss_rs2_en && mbusy[iss_rs2]) ||
               (iss_rd_en && mbusy[iss_rd]));
        chk("iss_ready", {63'd0, iss_ready}, {63'd0, ir});
        @(posedge clk);
        if (e_regwr) mbusy[e_rd] = 1'b0;
        if (iss_valid && ir && iss_rd_en && iss_rd != 0) mbusy[iss_rd] = 1'b1;
        if (win >= 0) begin
            e_rd    = rrd[win];
            e_data  = rdat[win];
            e_regwr = (win == 2) || (rrd[win] != 0);
            e_caddr = (win == 2) ? ccaddr : 12'h000;
            e_cctl  = (win == 2) ? ccctl  : 2'd0;
            mptr    = (win + 1) % 3;
        end else begin
            e_regwr = 1'b0;
        end
        last_win = win;
        #1;
        chk("RegWr", {63'd0, RegWr}, {63'd0, e_regwr});
        if (win >= 0) begin
            chk("rd", {59'd0, rd}, {59'd0, e_rd});
            chk("rd_data", {32'd0, rd_data}, {32'd0, e_data});
            chk("csr_addr", {52'd0, csrs_rs1_write_add}, {52'd0, e_caddr});
            chk("csr_ctl", {62'd0, csrs_ctl}, {62'd0, e_cctl});
        end
    endtask

    initial begin
        caddr_tab[0] = CSR_NONE;  caddr_tab[1] = CSR_MSTATUS; caddr_tab[2] = CSR_MTVEC;
        caddr_tab[3] = CSR_MEPC;  caddr_tab[4] = CSR_MCAUSE;
        model_reset();
        for (int r = 0; r < 3; r++) set_req(r, 1'b1, 5'(r + 1), 32'h1000 + r);
        ccaddr = CSR_MEPC; ccctl = 2'd1;
        set_iss(1'b0, 0, 0, 0, 0, 0, 0);
        drive();

        // Reset state with every requester asking
        rst_n = 1'b0;
        #12;
        chk("rst_ready", {61'd0, csr_ready, lsu_ready, exu_ready}, 64'd0);
        chk("rst_RegWr", {63'd0, RegWr}, 64'd0);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_data", {32'd0, rd_data}, 64'd0);
        chk("rst_caddr", {52'd0, csrs_rs1_write_add}, 64'd0);
        chk("rst_cctl", {62'd0, csrs_ctl}, 64'd0);
        for (int r = 0; r < 3; r++) rv[r] = 1'b0;
        drive();
        @(negedge clk) rst_n = 1'b1;
        step();

        // Single write-back with scoreboard round-trip on x5
        set_iss(1'b1, 0, 0, 0, 0, 5, 1); step();
        set_iss(1'b1, 5, 1, 0, 0, 0, 0);
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF); step();
        set_req(0, 1'b0, 5'd5, 32'hDEADBEEF); step();
        step();
        set_iss(1'b0, 0, 0, 0, 0, 0, 0);

        // Contention held continuously
        ccaddr = CSR_MSTATUS; ccctl = 2'd0;
        set_req(0, 1'b1, 5'd1, 32'hA0A0A0A0);
        set_req(1, 1'b1, 5'd2, 32'hB1B1B1B1);
        set_req(2, 1'b1, 5'd3, 32'hC2C2C2C2);
        repeat (6) step();
        // Each requester drops once served
        for (int i = 0; i < 3; i++) begin
            if (last_win >= 0) rv[last_win] = 1'b0;
            step();
        end
        for (int r = 0; r < 3; r++) rv[r] = 1'b0;
        step();

        // RAW / WAW on x7
        set_iss(1'b1, 0, 0, 0, 0, 7, 1); step();
        set_iss(1'b1, 7, 1, 0, 0, 0, 0); step(); step();
        set_iss(1'b1, 0, 0, 0, 0, 7, 1); step();
        set_iss(1'b1, 0, 0, 7, 1, 0, 0);
        set_req(1, 1'b1, 5'd7, 32'h77777777); step();
        rv[1] = 1'b0; step();
        step();
        set_iss(1'b0, 0, 0, 0, 0, 0, 0);

        // x0 handling
        set_req(1, 1'b1, 5'd0, 32'h12345678); step();
        rv[1] = 1'b0;
        ccaddr = CSR_MTVEC; ccctl = 2'd0;
        set_req(2, 1'b1, 5'd0, 32'h80000000); step();
        rv[2] = 1'b0;
        set_iss(1'b1, 0, 0, 0, 0, 0, 1); step();
        set_iss(1'b1, 0, 1, 0, 1, 0, 1); step();

        // Unscoreboarded x3 write retires while a new rd=3 issues
        set_iss(1'b0, 0, 0, 0, 0, 0, 0);
        set_req(0, 1'b1, 5'd3, 32'h33333333); step();
        rv[0] = 1'b0;
        set_iss(1'b1, 0, 0, 0, 0, 3, 1); step();
        set_iss(1'b1, 3, 1, 0, 0, 0, 0); step(); step();

        // Reset mid-transfer on a busy register
        set_iss(1'b1, 0, 0, 0, 0, 9, 1); step();
        set_iss(1'b1, 9, 1, 0, 0, 0, 0);
        set_req(0, 1'b1, 5'd9, 32'h99999999); step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_RegWr", {63'd0, RegWr}, 64'd0);
        chk("mid_rst_rd", {59'd0, rd}, 64'd0);
        chk("mid_rst_data", {32'd0, rd_data}, 64'd0);
        chk("mid_rst_ready", {61'd0, csr_ready, lsu_ready, exu_ready}, 64'd0);
        chk("mid_rst_busy9", {63'd0, iss_ready}, 64'd1);
        model_reset();
        rv[0] = 1'b0; drive();
        @(negedge clk) rst_n = 1'b1;
        step();

        // Randomised traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 3; r++) begin
                if (!rv[r] || last_win == r) begin
                    rv[r]   = ($urandom_range(0, 2) != 0);
                    rrd[r]  = 5'($urandom_range(0, 7));
                    rdat[r] = $urandom;
                    if (r == 2) begin
                        ccaddr = caddr_tab[$urandom_range(0, 4)];
                        ccctl  = 2'($urandom_range(0, 2));
                    end
                end
            end
            set_iss(1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
